thermo_stream_gen: RTL and testbench
====================================

// Module: thermo_stream_gen
// PURPOSE
//  Takes a binary count (0..SAMPLES*OSF) and emits SAMPLES thermometer-coded groups of OSF bits, one group per
//  accepted beat, with valid/ready handshake.
//  Regenerates an oversampled thermometer stream whose per-group thermo2bin decodes sum back to the count.
//  Sits upstream of the summation/decode chain; serves as a stimulus source and as a DAC-side encoder.
// PARAMETERS
//  SAMPLES  128  groups per frame; power of 2, >=2
//  OSF      8    bits per group (oversampling factor); 8 matches thermo2bin
//  CW = $clog2(SAMPLES*OSF)+1 (derived localparam)  count width
//  GW = $clog2(SAMPLES)       (derived localparam)  group index width
// PORTS
//  clk       in   1        single clock; all state on rising edge
//  rst_n     in   1        asynchronous, active-low reset
//  Enable    in   1        block enable; low = abort frame, refuse input
//  in_value  in   CW       binary count to encode
//  in_valid  in   1        in_value valid
//  in_ready  out  1        = Enable && state==IDLE (combinational from registered state)
//  Thermo    out  OSF      current group, LSB-first thermometer (k ones -> bits[k-1:0]=1)
//  out_idx   out  GW       index of current group, 0..SAMPLES-1
//  out_valid out  1        Thermo/out_idx/out_last valid
//  out_ready in   1        downstream accepts beat
//  out_last  out  1        high on group SAMPLES-1
//  sat       out  1        frame's in_value exceeded SAMPLES*OSF and was clamped; held for whole frame
// BEHAVIOUR
//  Reset: state=IDLE, Thermo=0, out_idx=0, out_valid=0, out_last=0, sat=0, remaining=0.
//  FSM IDLE: on in_valid&&in_ready -> latch min(in_value,SAMPLES*OSF) into remaining, set sat, go EMIT;
//   first group registered the same edge, so out_valid rises 1 cycle after acceptance.
//  FSM EMIT: outputs registered; beat retires when out_valid&&out_ready.
//   On a retired beat, next group is loaded, out_idx+1.
//   If the retired beat had out_last=1 -> IDLE, out_valid=0, sat=0.
//  Beat stability: while out_valid&&!out_ready, Thermo/out_idx/out_last/sat stay constant.
//  Sequential fill (default): group = min(remaining,OSF); remaining -= group per retired beat.
//   Groups 0..n-1 full (all ones), one partial group, rest zero.
//  Sum of popcount(Thermo) over a frame == clamped value, exactly.
//  Width rules: remaining is CW bits, never underflows (min before subtract). Clamp compares full CW width.
//  Throughput: 1 group/cycle with out_ready held high. One idle cycle between frames (in_ready only in IDLE).
//  Enable low in EMIT: at next edge -> IDLE, out_valid=0, beat discarded, no out_last emitted.
//  in_valid while in EMIT is ignored (in_ready=0); the source holds it.
//  rst_n asserted mid-frame: immediate async return to reset values; no partial beat visible after release.
// CONFIGURATION
//  THERMO_SPREAD_EN defined: even distribution.
//   base = v>>GW, extra = v & (SAMPLES-1); group i = base + (i<extra).
//   Two registers replace remaining; popcount sum still == clamped value.
//  Undefined: sequential fill as above. Handshake, latency, sat, and out_last are identical in both builds.
// STRUCTURE
//  thermo_pkg: state encoding (IDLE/EMIT) and CW/GW width helpers.
//  Sub-module bin2thermo (combinational): $clog2(OSF)+1-bit count -> OSF-bit LSB-first thermometer.
//   It is the exact inverse of thermo2bin.
// TESTING (SAMPLES=128, OSF=8 unless noted)
//  in_value=0 -> 128 beats Thermo=8'h00, idx 0..127, out_last only on idx127, sat=0.
//  in_value=1024 -> 128 beats 8'hFF. in_value=2000 -> same stream, sat=1 all 128 beats.
//  in_value=13 -> idx0 8'hFF, idx1 8'h1F, rest 8'h00.
//   With THERMO_SPREAD_EN: idx0..12 8'h01, rest 8'h00.
//  out_ready random 50% -> outputs stable while stalled; stream equal to unstalled run.
//   Feed every frame into Sumatoria; its output must equal the clamped in_value.
//  rst_n low at idx 40 -> all outputs 0 asynchronously. Next frame in_value=9 -> idx0 8'hFF, idx1 8'h01.
//  Enable low at idx 60 -> out_valid=0 next cycle, in_ready=0 while Enable low.
//   Enable high -> in_ready=1, new frame starts at idx0.

Source files
------------

// File: rtl/thermo_pkg.sv
// Shared state encoding and width helpers for the thermometer stream generator.
package thermo_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_t;

  // Count width: must hold SAMPLES*OSF itself, hence the extra bit.
  function automatic int cw_of(input int samples, input int osf);
    return $clog2(samples * osf) + 1;
  endfunction

  function automatic int gw_of(input int samples);
    return $clog2(samples);
  endfunction

  function automatic int ow_of(input int osf);
    return $clog2(osf) + 1;
  endfunction

endpackage

// File: rtl/bin2thermo.sv
// Combinational binary-to-thermometer encoder, LSB-first: count k sets bits[k-1:0].
// Exact inverse of thermo2bin for counts 0..OSF.
module bin2thermo
  import thermo_pkg::*;
#(
  parameter int OSF = 8
) (
  input  logic [ow_of(OSF)-1:0] cnt,
  output logic [OSF-1:0]        thermo
);

  for (genvar i = 0; i < OSF; i++) begin : g_bit
    assign thermo[i] = (32'(cnt) > 32'(i));
  end

endmodule

// File: rtl/thermo_stream_gen.sv
// Emits SAMPLES thermometer groups of OSF bits per accepted count, valid/ready on both sides.
// Build option THERMO_SPREAD_EN: spread the count evenly over all groups instead of filling sequentially.
//
// state | meaning
// IDLE  | waiting for a count; in_ready follows Enable
// EMIT  | streaming groups 0..SAMPLES-1; Enable low aborts the frame
module thermo_stream_gen
  import thermo_pkg::*;
#(
  parameter int SAMPLES = 128,
  parameter int OSF     = 8,
  localparam int CW     = cw_of(SAMPLES, OSF),
  localparam int GW     = gw_of(SAMPLES)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           Enable,
  input  logic [CW-1:0]  in_value,
  input  logic           in_valid,
  output logic           in_ready,
  output logic [OSF-1:0] Thermo,
  output logic [GW-1:0]  out_idx,
  output logic           out_valid,
  input  logic           out_ready,
  output logic           out_last,
  output logic           sat
);

  localparam int             OW       = ow_of(OSF);
  localparam logic [CW-1:0]  TOT      = CW'(SAMPLES * OSF);
  localparam logic [GW-1:0]  LAST_IDX = GW'(SAMPLES - 1);

  state_t         state, state_n;
  logic [OSF-1:0] thermo_n;
  logic [GW-1:0]  out_idx_n;
  logic           out_valid_n, out_last_n, sat_n;
  logic           load, clear;

  logic [CW-1:0]  clamped;
  logic [GW-1:0]  grp_idx;
  logic [OW-1:0]  grp_cnt;
  logic [OSF-1:0] grp_thermo;

  assign in_ready = Enable && (state == IDLE);
  assign clamped  = (in_value > TOT) ? TOT : in_value;
  // Index of the group about to be loaded: 0 on acceptance, else the next one.
  assign grp_idx  = (state == IDLE) ? '0 : out_idx + GW'(1);

`ifdef THERMO_SPREAD_EN
  logic [OW-1:0] base, base_src;
  logic [GW-1:0] extra, extra_src;

  always_comb begin
    base_src  = (state == IDLE) ? OW'(clamped >> GW) : base;
    extra_src = (state == IDLE) ? clamped[GW-1:0] : extra;
    grp_cnt   = base_src + OW'(grp_idx < extra_src);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      base  <= '0;
      extra <= '0;
    end else if (clear) begin
      base  <= '0;
      extra <= '0;
    end else if (load) begin
      base  <= base_src;
      extra <= extra_src;
    end
  end
`else
  logic [CW-1:0] remaining, rem_src, rem_left;

  // min() before the subtract keeps remaining from ever underflowing.
  always_comb begin
    rem_src  = (state == IDLE) ? clamped : remaining;
    grp_cnt  = (rem_src >= CW'(OSF)) ? OW'(OSF) : rem_src[OW-1:0];
    rem_left = rem_src - CW'(grp_cnt);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      remaining <= '0;
    end else if (clear) begin
      remaining <= '0;
    end else if (load) begin
      remaining <= rem_left;
    end
  end
`endif

  bin2thermo #(.OSF(OSF)) u_enc (
    .cnt    (grp_cnt),
    .thermo (grp_thermo)
  );

  always_comb begin
    state_n     = state;
    thermo_n    = Thermo;
    out_idx_n   = out_idx;
    out_valid_n = out_valid;
    out_last_n  = out_last;
    sat_n       = sat;
    load        = 1'b0;
    clear       = 1'b0;
    case (state)
      IDLE: begin
        if (in_ready && in_valid) begin
          state_n     = EMIT;
          load        = 1'b1;
          thermo_n    = grp_thermo;
          out_idx_n   = '0;
          out_valid_n = 1'b1;
          out_last_n  = 1'b0;
          sat_n       = (in_value > TOT);
        end
      end
      EMIT: begin
        if (!Enable || (out_valid && out_ready && out_last)) begin
          state_n     = IDLE;
          clear       = 1'b1;
          thermo_n    = '0;
          out_idx_n   = '0;
          out_valid_n = 1'b0;
          out_last_n  = 1'b0;
          sat_n       = 1'b0;
        end else if (out_valid && out_ready) begin
          load       = 1'b1;
          thermo_n   = grp_thermo;
          out_idx_n  = grp_idx;
          out_last_n = (grp_idx == LAST_IDX);
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      Thermo    <= '0;
      out_idx   <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      sat       <= 1'b0;
    end else begin
      state     <= state_n;
      Thermo    <= thermo_n;
      out_idx   <= out_idx_n;
      out_valid <= out_valid_n;
      out_last  <= out_last_n;
      sat       <= sat_n;
    end
  end

endmodule

// File: tb/tb_thermo_stream_gen.sv
// Bench for thermo_stream_gen: per-beat comparison against a group-level model plus literal frame checks.
module tb_thermo_stream_gen;

  localparam int SAMPLES = 128;
  localparam int OSF     = 8;
  localparam int CW      = 11;
  localparam int GW      = 7;
  localparam int TOT     = SAMPLES * OSF;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           Enable = 1'b0;
  logic [CW-1:0]  in_value = '0;
  logic           in_valid = 1'b0;
  logic           in_ready;
  logic [OSF-1:0] Thermo;
  logic [GW-1:0]  out_idx;
  logic           out_valid;
  logic           out_ready = 1'b0;
  logic           out_last;
  logic           sat;

  thermo_stream_gen #(.SAMPLES(SAMPLES), .OSF(OSF)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .Enable    (Enable),
    .in_value  (in_value),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .Thermo    (Thermo),
    .out_idx   (out_idx),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_last  (out_last),
    .sat       (sat)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  bit stall_mode = 1'b0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic int clamp_of(input int v);
    return (v > TOT) ? TOT : v;
  endfunction

  // Ones expected in group i of a frame carrying count v.
  function automatic int model_grp(input int v, input int i);
    int c;
    int r;
    c = clamp_of(v);
`ifdef THERMO_SPREAD_EN
    r = c / SAMPLES + ((i < (c % SAMPLES)) ? 1 : 0);
`else
    r = c - OSF * i;
    if (r < 0) r = 0;
    if (r > OSF) r = OSF;
`endif
    return r;
  endfunction

  function automatic logic [OSF-1:0] thermo_of(input int k);
    logic [OSF:0] t;
    t = (9'd1 << k) - 9'd1;
    return t[OSF-1:0];
  endfunction

  int             cur_v = 0;
  int             beat_cnt = 0;
  int             frame_sum = 0;
  int             frames_done = 0;
  bit             pend_first = 1'b0;
  bit             prev_stall = 1'b0;
  logic [OSF-1:0] cap0, cap1, hold_t;
  logic [GW-1:0]  hold_i;
  logic           cap_sat, hold_l, hold_s;

  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_stall = 1'b0;
        pend_first = 1'b0;
      end else begin
        if (pend_first) begin
          check("first_valid", out_valid, 1);
          check("first_idx", out_idx, 0);
          check("ready_in_emit", in_ready, 0);
          pend_first = 1'b0;
        end
        if (prev_stall && out_valid) begin
          check("stall_thermo", Thermo, hold_t);
          check("stall_idx", out_idx, hold_i);
          check("stall_last", out_last, hold_l);
          check("stall_sat", sat, hold_s);
        end
        prev_stall = out_valid && !out_ready && Enable;
        hold_t = Thermo;
        hold_i = out_idx;
        hold_l = out_last;
        hold_s = sat;
        if (out_valid && out_ready && Enable) begin
          check("beat_thermo", Thermo, thermo_of(model_grp(cur_v, beat_cnt)));
          check("beat_idx", out_idx, beat_cnt);
          check("beat_last", out_last, (beat_cnt == SAMPLES - 1) ? 1 : 0);
          check("beat_sat", sat, (cur_v > TOT) ? 1 : 0);
          if (beat_cnt == 0) begin
            cap0 = Thermo;
            cap_sat = sat;
          end
          if (beat_cnt == 1) cap1 = Thermo;
          frame_sum += $countones(Thermo);
          if (beat_cnt == SAMPLES - 1) begin
            check("frame_sum", frame_sum, clamp_of(cur_v));
            frames_done++;
          end
          beat_cnt++;
        end
        if (in_valid && in_ready) begin
          cur_v = int'(in_value);
          beat_cnt = 0;
          frame_sum = 0;
          pend_first = 1'b1;
        end
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      out_ready = stall_mode ? ($urandom_range(0, 1) == 1) : 1'b1;
    end
  end

  task automatic send(input int v);
    bit ok;
    ok = 1'b0;
    @(posedge clk);
    #1;
    in_value = CW'(v);
    in_valid = 1'b1;
    for (int c = 0; c < 200 && !ok; c++) begin
      @(negedge clk);
      if (in_ready) ok = 1'b1;
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check("accept", ok, 1);
  endtask

  task automatic wait_frame();
    int f0;
    int c;
    f0 = frames_done;
    c = 0;
    while (frames_done == f0 && c < 3000) begin
      @(posedge clk);
      c++;
    end
    check("frame_done", (frames_done != f0) ? 1 : 0, 1);
  endtask

  task automatic wait_beats(input int n);
    int c;
    c = 0;
    while (beat_cnt < n && c < 1000) begin
      @(posedge clk);
      #1;
      c++;
    end
    check("reach_beat", (beat_cnt >= n) ? 1 : 0, 1);
  endtask

  task automatic run_frame(input int v);
    send(v);
    wait_frame();
  endtask

  initial begin
    Enable = 1'b1;
    #12;
    check("rst_valid", out_valid, 0);
    check("rst_thermo", Thermo, 0);
    check("rst_idx", out_idx, 0);
    check("rst_last", out_last, 0);
    check("rst_sat", sat, 0);
    check("rst_ready", in_ready, 1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    run_frame(0);
    check("v0_g0", cap0, 8'h00);
    check("v0_sat", cap_sat, 0);
    run_frame(1024);
    check("v1024_g0", cap0, 8'hFF);
    check("v1024_sat", cap_sat, 0);
    run_frame(2000);
    check("v2000_g0", cap0, 8'hFF);
    check("v2000_sat", cap_sat, 1);
    run_frame(13);
`ifdef THERMO_SPREAD_EN
    check("v13_g0", cap0, 8'h01);
    check("v13_g1", cap1, 8'h01);
`else
    check("v13_g0", cap0, 8'hFF);
    check("v13_g1", cap1, 8'h1F);
`endif

    stall_mode = 1'b1;
    run_frame(13);
    run_frame(777);
    run_frame(1023);
    run_frame(2047);
    stall_mode = 1'b0;
    run_frame(8);
    run_frame(129);

    send(2000);
    wait_beats(40);
    check("pre_rst_idx", out_idx, 40);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_valid", out_valid, 0);
    check("arst_thermo", Thermo, 0);
    check("arst_idx", out_idx, 0);
    check("arst_last", out_last, 0);
    check("arst_sat", sat, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    run_frame(9);
`ifdef THERMO_SPREAD_EN
    check("v9_g0", cap0, 8'h01);
    check("v9_g1", cap1, 8'h01);
`else
    check("v9_g0", cap0, 8'hFF);
    check("v9_g1", cap1, 8'h01);
`endif

    send(700);
    wait_beats(60);
    check("pre_abort_idx", out_idx, 60);
    Enable = 1'b0;
    @(posedge clk);
    #1;
    check("abort_valid", out_valid, 0);
    check("abort_last", out_last, 0);
    check("abort_ready", in_ready, 0);
    repeat (3) @(posedge clk);
    #1;
    check("dis_ready", in_ready, 0);
    check("dis_valid", out_valid, 0);
    Enable = 1'b1;
    #1;
    check("en_ready", in_ready, 1);
    run_frame(500);
`ifdef THERMO_SPREAD_EN
    check("v500_g0", cap0, 8'h0F);
`else
    check("v500_g0", cap0, 8'hFF);
`endif

    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
